// File: rtl/dense_weight_scheduler_pkg.sv
// dense_sched_pkg: shared state encoding and buffer sizing for the dense weight scheduler
package dense_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam int BUF_DEPTH = 2;
endpackage

// File: rtl/dense_weight_scheduler_if.sv
// dense_weight_scheduler_if: weight stream handshake from scheduler to MAC array
interface dense_weight_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int NROWW = 10
);
  logic             w_valid;
  logic             w_ready;
  logic [WIDTH-1:0] w_data;
  logic             w_row_last;
  logic [NROWW-1:0] w_row_idx;
  modport master(output w_valid, w_data, w_row_last, w_row_idx, input w_ready);
  modport slave(input w_valid, w_data, w_row_last, w_row_idx, output w_ready);
endinterface

// File: rtl/dense_weight_scheduler_fifo.sv
// dense_weight_skid_fifo: 2-entry buffer absorbing the ROM read latency under back-pressure
module dense_weight_skid_fifo import dense_sched_pkg::*; #(
  parameter int W = 43
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = push && !flush ? din : mem_q[wr_q];
    wr_d = flush ? 1'b0 : wr_q ^ push;
    rd_d = flush ? 1'b0 : rd_q ^ pop;
    count_d = flush ? 2'd0 : count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end

  assign dout = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/dense_weight_scheduler.sv
// dense_weight_scheduler: walks the dense weight ROM for one layer and streams words with credit-based flow control
module dense_weight_scheduler import dense_sched_pkg::*; #(
  parameter int DEPTH = 16384,
  parameter int WIDTH = 32,
  parameter int ROWW = 12,
  parameter int NROWW = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [AW-1:0]            cfg_base_addr,
  input  logic [ROWW-1:0]          cfg_row_words,
  input  logic [NROWW-1:0]         cfg_num_rows,
  output logic [AW-1:0]            rom_addr,
  output logic                     rom_read_enable,
  input  logic [WIDTH-1:0]         rom_data,
  dense_weight_scheduler_if.master w,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_error
);
  localparam int CW = AW + ROWW + NROWW;
  localparam int EW = 1 + NROWW + WIDTH;

  state_e           state_q, state_d;
  logic [AW-1:0]    base_q, base_d, lin_q, lin_d, last_addr_q, last_addr_d;
  logic [ROWW-1:0]  row_words_q, row_words_d, word_q, word_d;
  logic [NROWW-1:0] num_rows_q, num_rows_d, row_q, row_d, tag_idx_q, tag_idx_d;
  logic             tag_last_q, tag_last_d, inflight_q, inflight_d;
  logic             busy_q, busy_d, done_q, done_d, cfg_error_q, cfg_error_d;
  logic [1:0]       count;
  logic [EW-1:0]    head;
  logic             pop, issue, cfg_ok, word_last, final_word;

  assign pop = w.w_valid & w.w_ready;
  assign w.w_valid = count != 2'd0;
  assign {w.w_row_last, w.w_row_idx, w.w_data} = head;
  assign word_last = word_q == row_words_q - ROWW'(1);
  assign final_word = word_last && row_q == num_rows_q - NROWW'(1);
  // credit: buffered + in-flight words after this cycle's pop must leave room for one more
  assign issue = state_q == RUN && !abort && 3'(count) + 3'(inflight_q) < 3'(BUF_DEPTH) + 3'(pop);
  assign rom_read_enable = issue;
  assign rom_addr = issue ? base_q + lin_q : last_addr_q;
  assign cfg_ok = cfg_row_words != '0 && cfg_num_rows != '0 &&
                  CW'(cfg_base_addr) + CW'(cfg_row_words) * CW'(cfg_num_rows) <= CW'(DEPTH);

  always_comb begin
    state_d = state_q;
    base_d = base_q;
    row_words_d = row_words_q;
    num_rows_d = num_rows_q;
    lin_d = issue ? lin_q + AW'(1) : lin_q;
    word_d = issue ? (word_last ? '0 : word_q + ROWW'(1)) : word_q;
    row_d = issue && word_last ? row_q + NROWW'(1) : row_q;
    last_addr_d = issue ? rom_addr : last_addr_q;
    tag_last_d = issue ? word_last : tag_last_q;
    tag_idx_d = issue ? row_q : tag_idx_q;
    inflight_d = issue;
    cfg_error_d = 1'b0;
    if (abort) state_d = IDLE;
    else if (state_q == IDLE && start) begin
      cfg_error_d = !cfg_ok;
      if (cfg_ok) begin
        state_d = RUN;
        base_d = cfg_base_addr;
        row_words_d = cfg_row_words;
        num_rows_d = cfg_num_rows;
        lin_d = '0;
        word_d = '0;
        row_d = '0;
      end
    end
    else if (state_q == RUN && issue && final_word) state_d = DRAIN;
    else if (state_q == DRAIN && 3'(count) + 3'(inflight_q) == 3'(pop)) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
    busy_d = state_d == RUN || state_d == DRAIN;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q <= '0;
      row_words_q <= '0;
      num_rows_q <= '0;
      lin_q <= '0;
      word_q <= '0;
      row_q <= '0;
      last_addr_q <= '0;
      tag_last_q <= 1'b0;
      tag_idx_q <= '0;
      inflight_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      row_words_q <= row_words_d;
      num_rows_q <= num_rows_d;
      lin_q <= lin_d;
      word_q <= word_d;
      row_q <= row_d;
      last_addr_q <= last_addr_d;
      tag_last_q <= tag_last_d;
      tag_idx_q <= tag_idx_d;
      inflight_q <= inflight_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  dense_weight_skid_fifo #(.W(EW)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(abort),
    .push (inflight_q),
    .pop  (pop),
    .din  ({tag_last_q, tag_idx_q, rom_data}),
    .dout (head),
    .count(count)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign cfg_error = cfg_error_q;
endmodule
